// File: rtl/memory_access_stage.sv
// memory_access_stage -- MEM stage of the pipelined RV32I core.
//
// Takes the EX/MEM register outputs, runs loads/stores over a req/ack data
// bus with byte lanes, sign/zero-extends load data, stalls upstream while an
// access is outstanding and holds the MEM/WB pipeline register.
//
// Parameter:
//   TIMEOUT_CYCLES  stall cycles before an unacknowledged access is aborted
//                   (0 = wait forever)
// Optional build macro:
//   MISALIGN_TRAP_EN  misaligned H/W accesses are suppressed and reported on
//                     o_MisalignW instead of going to the bus
//
// Ports:
//   i_Clk, i_Reset (async, active-low)
//   EX/MEM in : i_ALUResultM, i_WriteDataM, i_RdM, i_PCPlus4M, i_RegWriteM,
//               i_MemReadM, i_MemWriteM, i_Funct3M, i_ResultSrcM
//   bus       : o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemBe,
//               i_MemRData, i_MemAck
//   control   : o_StallM
//   MEM/WB out: o_ResultW, o_RdW, o_RegWriteW, o_BusErrW (, o_MisalignW)
//
// FSM states:
//   state  | meaning
//   S_IDLE | no access outstanding; a new access may complete with zero wait
//   S_WAIT | access issued, waiting for i_MemAck or timeout
module memory_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic [31:0] i_ALUResultM,
   input  logic [31:0] i_WriteDataM,
   input  logic [4:0]  i_RdM,
   input  logic [31:0] i_PCPlus4M,
   input  logic        i_RegWriteM,
   input  logic        i_MemReadM,
   input  logic        i_MemWriteM,
   input  logic [2:0]  i_Funct3M,
   input  logic [1:0]  i_ResultSrcM,
   output logic        o_MemReq,
   output logic        o_MemWe,
   output logic [31:0] o_MemAddr,
   output logic [31:0] o_MemWData,
   output logic [3:0]  o_MemBe,
   input  logic [31:0] i_MemRData,
   input  logic        i_MemAck,
   output logic        o_StallM,
   output logic [31:0] o_ResultW,
   output logic [4:0]  o_RdW,
   output logic        o_RegWriteW,
   output logic        o_BusErrW
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        o_MisalignW
`endif
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc, misalign, req_int, timeout_hit;
   logic [1:0]       lane;
   logic             is_byte, is_half;
   logic [3:0]       st_be;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_data, result_mux;

   assign acc     = i_MemReadM | i_MemWriteM;
   assign lane    = i_ALUResultM[1:0];
   // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined) is a word
   assign is_byte = (i_Funct3M[1:0] == 2'b00);
   assign is_half = (i_Funct3M[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
   assign misalign = acc & ((is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   assign req_int = acc & ~misalign;

   // Ack arriving in the timeout cycle completes the access normally
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !i_MemAck;

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter holds the number of stall cycles already spent on this access,
   // so the abort lands after exactly TIMEOUT_CYCLES stalled cycles.
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      o_StallM = 1'b0;
      case (state_q)
         S_IDLE:  if (req_int && !i_MemAck) state_d = S_WAIT;
         S_WAIT:  if (i_MemAck || timeout_hit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_WAIT) cnt_d = cnt_q + 1'b1;
      // Gating with i_Reset lets the async reset release the bus immediately
      o_StallM = req_int & ~i_MemAck & ~timeout_hit & i_Reset;
   end

   assign o_MemReq  = req_int & i_Reset;
   assign o_MemWe   = i_MemWriteM;
   assign o_MemAddr = {i_ALUResultM[31:2], 2'b00};

   always_comb begin
      st_be      = 4'b1111;
      o_MemWData = i_WriteDataM;
      if (is_byte) begin
         st_be      = 4'b0001 << lane;
         o_MemWData = {4{i_WriteDataM[7:0]}};
      end else if (is_half) begin
         st_be      = 4'b0011 << {lane[1], 1'b0};
         o_MemWData = {2{i_WriteDataM[15:0]}};
      end
      if (i_MemReadM)       o_MemBe = 4'b1111;
      else if (i_MemWriteM) o_MemBe = st_be;
      else                  o_MemBe = 4'b0000;
   end

   always_comb begin
      case (lane)
         2'd0:    ld_byte = i_MemRData[7:0];
         2'd1:    ld_byte = i_MemRData[15:8];
         2'd2:    ld_byte = i_MemRData[23:16];
         default: ld_byte = i_MemRData[31:24];
      endcase
      ld_half = lane[1] ? i_MemRData[31:16] : i_MemRData[15:0];
      case (i_Funct3M)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = i_MemRData;
      endcase
      case (i_ResultSrcM)
         2'b01:   result_mux = ld_data;
         2'b10:   result_mux = i_PCPlus4M;
         default: result_mux = i_ALUResultM;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         o_ResultW   <= '0;
         o_RdW       <= '0;
         o_RegWriteW <= 1'b0;
         o_BusErrW   <= 1'b0;
      end else if (o_StallM) begin
         o_RegWriteW <= 1'b0;
         o_BusErrW   <= 1'b0;
      end else begin
         o_ResultW   <= result_mux;
         o_RdW       <= i_RdM;
         o_RegWriteW <= i_RegWriteM & ~timeout_hit & ~misalign;
         o_BusErrW   <= timeout_hit;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset)      o_MisalignW <= 1'b0;
      else if (o_StallM) o_MisalignW <= 1'b0;
      else               o_MisalignW <= misalign;
   end
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

   localparam int T = 4;

   logic        i_Clk = 1'b0;
   logic        i_Reset;
   logic [31:0] i_ALUResultM, i_WriteDataM, i_PCPlus4M, i_MemRData;
   logic [4:0]  i_RdM;
   logic        i_RegWriteM, i_MemReadM, i_MemWriteM, i_MemAck;
   logic [2:0]  i_Funct3M;
   logic [1:0]  i_ResultSrcM;
   logic        o_MemReq, o_MemWe, o_StallM, o_RegWriteW, o_BusErrW;
   logic [31:0] o_MemAddr, o_MemWData, o_ResultW;
   logic [3:0]  o_MemBe;
   logic [4:0]  o_RdW;
`ifdef MISALIGN_TRAP_EN
   logic        o_MisalignW;
`endif

   memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset),
      .i_ALUResultM(i_ALUResultM), .i_WriteDataM(i_WriteDataM), .i_RdM(i_RdM),
      .i_PCPlus4M(i_PCPlus4M), .i_RegWriteM(i_RegWriteM), .i_MemReadM(i_MemReadM),
      .i_MemWriteM(i_MemWriteM), .i_Funct3M(i_Funct3M), .i_ResultSrcM(i_ResultSrcM),
      .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr),
      .o_MemWData(o_MemWData), .o_MemBe(o_MemBe), .i_MemRData(i_MemRData),
      .i_MemAck(i_MemAck), .o_StallM(o_StallM), .o_ResultW(o_ResultW),
      .o_RdW(o_RdW), .o_RegWriteW(o_RegWriteW), .o_BusErrW(o_BusErrW)
`ifdef MISALIGN_TRAP_EN
      , .o_MisalignW(o_MisalignW)
`endif
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        rw;
      logic        err;
      logic        mis;
   } wb_t;

   wb_t sb_q[$];
   int  n_vec  = 0;
   int  n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives one instruction (called just after a rising edge), answers the bus
   // after ack_dly cycles (-1 = never) and checks stall/bubbles/retirement.
   task automatic issue(input string tag,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] pc4, input logic rw, input logic mr, input logic mw,
                        input logic [2:0] f3, input logic [1:0] rs, input logic [31:0] rdata,
                        input int ack_dly, input logic exp_req, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_res,
                        input logic exp_rw, input logic exp_err, input logic exp_mis);
      logic done;
      logic exp_stall;
      wb_t  wb;
      i_ALUResultM = alu;  i_WriteDataM = wd;  i_RdM = rd;   i_PCPlus4M = pc4;
      i_RegWriteM  = rw;   i_MemReadM   = mr;  i_MemWriteM = mw;
      i_Funct3M    = f3;   i_ResultSrcM = rs;
      i_MemAck     = 1'b0; i_MemRData   = 32'h0;
      sb_q.push_back('{res: exp_res, rd: rd, rw: exp_rw, err: exp_err, mis: exp_mis});
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         if (ack_dly >= 0 && c == ack_dly) begin
            i_MemAck   = 1'b1;
            i_MemRData = rdata;
         end
         #1;
         exp_stall = exp_req && ((ack_dly >= 0) ? (c < ack_dly) : (c < T));
         if (c == 0) begin
            check({tag, ".req"}, {31'd0, o_MemReq}, {31'd0, exp_req});
            if (exp_req) begin
               check({tag, ".addr"}, o_MemAddr, {alu[31:2], 2'b00});
               check({tag, ".be"}, {28'd0, o_MemBe}, {28'd0, exp_be});
               check({tag, ".we"}, {31'd0, o_MemWe}, {31'd0, mw});
               if (mw) check({tag, ".wdata"}, o_MemWData, exp_wd);
            end
         end
         check({tag, ".stall"}, {31'd0, o_StallM}, {31'd0, exp_stall});
         @(posedge i_Clk);
         #1;
         if (!exp_stall) begin
            wb = sb_q.pop_front();
            check({tag, ".regwrite"}, {31'd0, o_RegWriteW}, {31'd0, wb.rw});
            check({tag, ".rd"}, {27'd0, o_RdW}, {27'd0, wb.rd});
            if (wb.rw) check({tag, ".result"}, o_ResultW, wb.res);
            check({tag, ".buserr"}, {31'd0, o_BusErrW}, {31'd0, wb.err});
`ifdef MISALIGN_TRAP_EN
            check({tag, ".misalign"}, {31'd0, o_MisalignW}, {31'd0, wb.mis});
`endif
            done = 1'b1;
         end else begin
            check({tag, ".bubble_rw"}, {31'd0, o_RegWriteW}, 32'd0);
            check({tag, ".bubble_err"}, {31'd0, o_BusErrW}, 32'd0);
         end
      end
      if (!done) check({tag, ".cycle_budget"}, 32'd0, 32'd1);
      i_MemAck = 1'b0;
   endtask

   task automatic idle_inputs();
      i_ALUResultM = '0; i_WriteDataM = '0; i_RdM = '0; i_PCPlus4M = '0;
      i_RegWriteM = 0; i_MemReadM = 0; i_MemWriteM = 0; i_Funct3M = '0;
      i_ResultSrcM = '0; i_MemAck = 0; i_MemRData = '0;
   endtask

   initial begin
      i_Reset = 1'b0;
      idle_inputs();
      #1;
      check("rst.result", o_ResultW, 32'd0);
      check("rst.rd", {27'd0, o_RdW}, 32'd0);
      check("rst.regwrite", {31'd0, o_RegWriteW}, 32'd0);
      check("rst.buserr", {31'd0, o_BusErrW}, 32'd0);
      check("rst.req", {31'd0, o_MemReq}, 32'd0);
      repeat (2) @(posedge i_Clk);
      @(negedge i_Clk);
      i_Reset = 1'b1;
      @(posedge i_Clk);
      #1;

      //    tag       alu           wd            rd     pc4        rw mr mw f3      rs     rdata         dly req be       wdata         result        rw err mis
      issue("alu",   32'h1234,     32'h0,        5'd5,  32'h0,     1, 0, 0, 3'b000, 2'b00, 32'h0,         -1, 0, 4'b0000, 32'h0,        32'h1234,     1, 0, 0);
      issue("ackidl",32'h55AA,     32'h0,        5'd7,  32'h0,     1, 0, 0, 3'b000, 2'b11, 32'hFFFF_FFFF,  0, 0, 4'b0000, 32'h0,        32'h55AA,     1, 0, 0);
      issue("sb",    32'h103,      32'hAB,       5'd0,  32'h0,     0, 0, 1, 3'b000, 2'b00, 32'h0,          0, 1, 4'b1000, 32'hABABABAB, 32'h0,        0, 0, 0);
      issue("sh",    32'h102,      32'h1234BEEF, 5'd0,  32'h0,     0, 0, 1, 3'b001, 2'b00, 32'h0,          1, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 0);
      issue("sw",    32'h200,      32'hDEADBEEF, 5'd0,  32'h0,     0, 0, 1, 3'b010, 2'b00, 32'h0,          0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 0);
      issue("lb",    32'h102,      32'h0,        5'd10, 32'h0,     1, 1, 0, 3'b000, 2'b01, 32'h00800000,   3, 1, 4'b1111, 32'h0,        32'hFFFFFF80, 1, 0, 0);
      issue("lhu",   32'h102,      32'h0,        5'd11, 32'h0,     1, 1, 0, 3'b101, 2'b01, 32'h80010000,   0, 1, 4'b1111, 32'h0,        32'h00008001, 1, 0, 0);
      issue("lh",    32'h100,      32'h0,        5'd12, 32'h0,     1, 1, 0, 3'b001, 2'b01, 32'h0000F00F,   1, 1, 4'b1111, 32'h0,        32'hFFFFF00F, 1, 0, 0);
      issue("lbu",   32'h101,      32'h0,        5'd13, 32'h0,     1, 1, 0, 3'b100, 2'b01, 32'h0000C300,   0, 1, 4'b1111, 32'h0,        32'h000000C3, 1, 0, 0);
      issue("lw",    32'h104,      32'h0,        5'd14, 32'h0,     1, 1, 0, 3'b010, 2'b01, 32'h89ABCDEF,   2, 1, 4'b1111, 32'h0,        32'h89ABCDEF, 1, 0, 0);
      issue("lundef",32'h108,      32'h0,        5'd15, 32'h0,     1, 1, 0, 3'b111, 2'b01, 32'h13579BDF,   0, 1, 4'b1111, 32'h0,        32'h13579BDF, 1, 0, 0);
      issue("jal",   32'h9999,     32'h0,        5'd1,  32'h44,    1, 0, 0, 3'b000, 2'b10, 32'h0,         -1, 0, 4'b0000, 32'h0,        32'h44,       1, 0, 0);
      issue("src11", 32'h77,       32'h0,        5'd2,  32'h88,    1, 0, 0, 3'b000, 2'b11, 32'h0,         -1, 0, 4'b0000, 32'h0,        32'h77,       1, 0, 0);
      issue("ackto", 32'h10C,      32'h0,        5'd16, 32'h0,     1, 1, 0, 3'b010, 2'b01, 32'h2468ACE0,   T, 1, 4'b1111, 32'h0,        32'h2468ACE0, 1, 0, 0);
      issue("tmo",   32'h110,      32'h0,        5'd3,  32'h0,     1, 1, 0, 3'b010, 2'b01, 32'h0,         -1, 1, 4'b1111, 32'h0,        32'h0,        0, 1, 0);
      issue("after", 32'hCAFE,     32'h0,        5'd4,  32'h0,     1, 0, 0, 3'b000, 2'b00, 32'h0,         -1, 0, 4'b0000, 32'h0,        32'hCAFE,     1, 0, 0);
`ifdef MISALIGN_TRAP_EN
      issue("mis",   32'h101,      32'h0,        5'd6,  32'h0,     1, 1, 0, 3'b010, 2'b01, 32'h11223344,  -1, 0, 4'b1111, 32'h0,        32'h0,        0, 0, 1);
      issue("nomis", 32'h4,        32'h0,        5'd8,  32'h0,     1, 0, 0, 3'b000, 2'b00, 32'h0,         -1, 0, 4'b0000, 32'h0,        32'h4,        1, 0, 0);
`else
      issue("mis",   32'h101,      32'h0,        5'd6,  32'h0,     1, 1, 0, 3'b010, 2'b01, 32'h11223344,   0, 1, 4'b1111, 32'h0,        32'h11223344, 1, 0, 0);
`endif

      // Reset asserted in the middle of a wait must release the bus at once
      i_ALUResultM = 32'h120; i_RdM = 5'd9; i_RegWriteM = 1; i_MemReadM = 1;
      i_Funct3M = 3'b010; i_ResultSrcM = 2'b01; i_MemAck = 0;
      @(posedge i_Clk);
      #1;
      @(posedge i_Clk);
      #1;
      check("rstmid.stall_before", {31'd0, o_StallM}, 32'd1);
      i_Reset = 1'b0;
      #1;
      check("rstmid.req", {31'd0, o_MemReq}, 32'd0);
      check("rstmid.stall", {31'd0, o_StallM}, 32'd0);
      check("rstmid.result", o_ResultW, 32'd0);
      check("rstmid.regwrite", {31'd0, o_RegWriteW}, 32'd0);
      idle_inputs();
      @(negedge i_Clk);
      i_Reset = 1'b1;
      @(posedge i_Clk);
      #1;
      issue("postrst",32'h3C,      32'h0,        5'd17, 32'h0,     1, 1, 0, 3'b010, 2'b01, 32'h0F0F0F0F,   1, 1, 4'b1111, 32'h0,        32'h0F0F0F0F, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
